// File: rtl/rv_pkg.sv
// Shared RV32 memory-stage definitions: opcodes, funct3 codes, trap causes, LSU states.
// Also hosts the legality/alignment check used when the effective address is formed.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_NONE        = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_ADDR,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

  // Illegal funct3 takes priority over misalignment.
  function automatic logic [3:0] lsu_check(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] ea_lo);
    logic legal;
    logic misal;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
    misal = ((f3[1:0] == 2'b01) && ea_lo[0]) || ((f3[1:0] == 2'b10) && (ea_lo != 2'b00));
    if (!legal) return CAUSE_ILLEGAL;
    if (misal)  return is_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store replication/byte enables and load extract/extend.
// Zero latency, no flow control; the caller qualifies the outputs by state.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic [31:0] sh_b;
  logic [31:0] sh_h;

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << ea_lo;
      end
      2'b01: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = 4'b0011 << ea_lo;
      end
      default: ;
    endcase
  end

  assign sh_b = rdata >> {ea_lo, 3'b000};
  assign sh_h = rdata >> {ea_lo[1], 4'b0000};

  always_comb begin
    ld_data = rdata;
    case (funct3)
      F3_B:    ld_data = {{24{sh_b[7]}}, sh_b[7:0]};
      F3_H:    ld_data = {{16{sh_h[15]}}, sh_h[15:0]};
      F3_BU:   ld_data = {24'd0, sh_b[7:0]};
      F3_HU:   ld_data = {16'd0, sh_h[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32 memory stage: one LOAD/STORE per handshake, EA + legality, req/gnt/rvalid memory port.
// Latency accept->done: exc 1, store 2+gnt wait, load 3+gnt+rvalid waits; req_ready low while busy.
module load_store_unit
  import rv_pkg::*;
#(
  parameter int MEM_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [31:0]       exc_addr
);

  lsu_state_e        state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [1:0]        ea_lo_q, ea_lo_d;

  logic              req_ready_q, req_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              done_q, done_d;
  logic              exc_valid_q, exc_valid_d;
  logic [3:0]        exc_cause_q, exc_cause_d;
  logic [31:0]       exc_addr_q, exc_addr_d;

  logic [31:0]       ea_sum;
  logic [3:0]        chk_cause;
  logic [1:0]        align_ea_lo;
  logic [31:0]       st_wdata;
  logic [3:0]        st_be;
  logic [31:0]       ld_data;

  assign ea_sum      = base_q + imm_q;
  assign chk_cause   = lsu_check(store_q, funct3_q, ea_sum[1:0]);
  // ADDR steers store lanes from the fresh sum; WAIT uses the registered offset.
  assign align_ea_lo = (state_q == LSU_ADDR) ? ea_sum[1:0] : ea_lo_q;

  lsu_align u_align (
    .funct3   (funct3_q),
    .ea_lo    (align_ea_lo),
    .st_data  (wdata_q),
    .rdata    (mem_rdata),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    base_d      = base_q;
    imm_d       = imm_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    ea_lo_d     = ea_lo_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    done_d      = 1'b0;
    exc_valid_d = 1'b0;
    exc_cause_d = 4'd0;
    exc_addr_d  = 32'd0;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          store_d     = req_store;
          funct3_d    = req_funct3;
          base_d      = req_base;
          imm_d       = req_imm;
          wdata_d     = req_wdata;
          rd_d        = req_rd;
          req_ready_d = 1'b0;
          state_d     = LSU_ADDR;
        end
      end
      LSU_ADDR: begin
        ea_lo_d = ea_sum[1:0];
        if (chk_cause != CAUSE_NONE) begin
          done_d      = 1'b1;
          exc_valid_d = 1'b1;
          exc_cause_d = chk_cause;
          exc_addr_d  = ea_sum;
          state_d     = LSU_RESP;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = store_q;
          mem_addr_d  = ea_sum[MEM_AW+1:2];
          mem_wdata_d = store_q ? st_wdata : 32'd0;
          mem_be_d    = store_q ? st_be : 4'b1111;
          state_d     = LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = 32'd0;
          mem_be_d    = 4'd0;
          if (store_q) begin
            done_d  = 1'b1;
            state_d = LSU_RESP;
          end else begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = ld_data;
          done_d     = 1'b1;
          state_d    = LSU_RESP;
        end
      end
      LSU_RESP: begin
        req_ready_d = 1'b1;
        state_d     = LSU_IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'd0;
      base_q      <= 32'd0;
      imm_q       <= 32'd0;
      wdata_q     <= 32'd0;
      rd_q        <= 5'd0;
      ea_lo_q     <= 2'd0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      done_q      <= 1'b0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= 4'd0;
      exc_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      base_q      <= base_d;
      imm_q       <= imm_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      ea_lo_q     <= ea_lo_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      done_q      <= done_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign done      = done_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized ops against a reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_imm, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        wb_valid, done, exc_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, exc_addr;
  logic [3:0]  exc_cause;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .done(done),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem     [32];  // responder memory, written from DUT store outputs
  logic [31:0] ref_mem [32];  // model memory, written from the reference model

  // Observations of the last operation (cycle numbers count edges after accept)
  int          o_done_c, o_wb_c, o_req_cnt, o_done_cnt, o_wb_cnt, o_exc_cnt;
  logic [4:0]  o_addr, o_wb_rd;
  logic        o_we, o_stable, o_ready_low, o_ready_after;
  logic [3:0]  o_be, o_cause;
  logic [31:0] o_wdata, o_wb_data, o_exc_addr;

  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wd,
                       output logic [3:0] cause, output logic [31:0] ea, output logic [4:0] widx,
                       output logic [3:0] be, output logic [31:0] mwd, output logic [31:0] ld);
    int sz, off;
    bit legal, uns;
    logic [31:0] w, v, mask;
    ea    = base + imm;
    sz    = int'(f3) % 4;
    uns   = (f3 >= 4);
    off   = int'(ea % 4);
    widx  = 5'((ea / 4) % 32);
    legal = st ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    if (!legal) cause = 4'd2;
    else if ((sz == 1 && ea % 2 != 0) || (sz == 2 && ea % 4 != 0)) cause = st ? 4'd6 : 4'd4;
    else cause = 4'd0;
    if (!st || sz == 2) be = 4'd15;
    else if (sz == 0) be = 4'(1 << off);
    else be = 4'(3 << off);
    if (sz == 0) mwd = (wd % 256) * 32'h01010101;
    else if (sz == 1) mwd = (wd % 65536) * 32'h00010001;
    else mwd = wd;
    w = ref_mem[widx];
    if (sz == 0) begin
      v = (w >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 1) begin
      v = (w >> (8 * off)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF0000;
    end else v = w;
    ld = v;
    if (st && cause == 0)
      for (int i = 0; i < 4; i++)
        if ((be >> i) % 2 == 1) begin
          mask = 32'hFF << (8 * i);
          ref_mem[widx] = (ref_mem[widx] & ~mask) | (mwd & mask);
        end
  endtask

  // Drives one request and plays the memory; records observations in o_*.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] wd, input logic [4:0] rd,
                        input int gd, input int rvd, input bit pre_acc, input bit keep_valid);
    int c, gcnt, rcnt;
    bit granted, rv_done;
    if (!pre_acc) begin
      int w = 0;
      while (req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) begin n_cmp++; n_bad++; $display("FAIL ready_wait: req_ready=%b required 1", req_ready); end
      req_store = st; req_funct3 = f3; req_base = base; req_imm = imm;
      req_wdata = wd; req_rd = rd; req_valid = 1'b1;
    end
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    o_done_c = -1; o_wb_c = -1; o_req_cnt = 0; o_done_cnt = 0; o_wb_cnt = 0; o_exc_cnt = 0;
    o_stable = 1'b1; o_ready_low = 1'b1; o_ready_after = 1'b0;
    o_addr = '0; o_we = 1'b0; o_be = '0; o_wdata = '0; o_cause = '0; o_exc_addr = '0;
    o_wb_data = '0; o_wb_rd = '0;
    granted = 0; rv_done = 0; gcnt = 0; rcnt = 0; c = 0;
    while (c < 60) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (o_done_c >= 0) begin o_ready_after = (req_ready === 1'b1); break; end
      if (req_ready !== 1'b0) o_ready_low = 1'b0;
      if (mem_req === 1'b1) begin
        if (o_req_cnt == 0) begin o_addr = mem_addr; o_we = mem_we; o_be = mem_be; o_wdata = mem_wdata; end
        else if (mem_addr !== o_addr || mem_we !== o_we || mem_be !== o_be || mem_wdata !== o_wdata) o_stable = 1'b0;
        o_req_cnt++;
        if (!granted) begin
          if (gcnt == gd) begin
            mem_gnt = 1'b1; granted = 1;
            if (mem_we === 1'b1)
              for (int i = 0; i < 4; i++) if (mem_be[i]) mem[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
          end else gcnt++;
        end
      end else if (granted && !o_we && !rv_done) begin
        if (rcnt == rvd) begin mem_rvalid = 1'b1; mem_rdata = mem[o_addr]; rv_done = 1; end
        else rcnt++;
      end
      if (done === 1'b1) begin o_done_cnt++; if (o_done_c < 0) o_done_c = c; end
      if (wb_valid === 1'b1) begin o_wb_cnt++; o_wb_c = c; o_wb_data = wb_data; o_wb_rd = wb_rd; end
      if (exc_valid === 1'b1) begin o_exc_cnt++; o_cause = exc_cause; o_exc_addr = exc_addr; end
      @(negedge clk);
      c++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (c >= 60) begin n_cmp++; n_bad++; $display("FAIL op_timeout: done never seen within 60 cycles"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if ({wb_valid, done, exc_valid, mem_we} !== 4'b0) begin n_bad++; $display("FAIL rst_pulses: got %b want 0", {wb_valid, done, exc_valid, mem_we}); end
    n_cmp++; if ({mem_be, mem_addr, mem_wdata, wb_data, exc_cause, exc_addr} !== '0) begin n_bad++; $display("FAIL rst_buses: nonzero output bus after reset"); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_release: ready=%b mem_req=%b want 1/0", req_ready, mem_req); end
  endtask

  task automatic test_lw();
    mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    run_op(1'b0, 3'b010, 32'h10, 32'd4, 32'd0, 5'd9, 0, 0, 0, 0);
    n_cmp++; if (o_addr !== 5'd5) begin n_bad++; $display("FAIL lw_addr: got %0d want 5", o_addr); end
    n_cmp++; if (o_we !== 1'b0 || o_be !== 4'hF) begin n_bad++; $display("FAIL lw_we_be: we=%b be=%b want 0/1111", o_we, o_be); end
    n_cmp++; if (o_wb_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data: got %h want deadbeef", o_wb_data); end
    n_cmp++; if (o_wb_c !== 3 || o_wb_cnt !== 1) begin n_bad++; $display("FAIL lw_wb_timing: cycle %0d count %0d want 3/1", o_wb_c, o_wb_cnt); end
    n_cmp++; if (o_wb_rd !== 5'd9) begin n_bad++; $display("FAIL lw_rd: got %0d want 9", o_wb_rd); end
    n_cmp++; if (o_ready_after !== 1'b1 || o_ready_low !== 1'b1) begin n_bad++; $display("FAIL lw_ready: after=%b low=%b want 1/1", o_ready_after, o_ready_low); end
  endtask

  task automatic test_lb_lbu();
    mem[5] = 32'h80FF1234; ref_mem[5] = 32'h80FF1234;
    run_op(1'b0, 3'b000, 32'h10, 32'd7, 32'd0, 5'd3, 0, 0, 0, 0);
    n_cmp++; if (o_wb_data !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_data: got %h want ffffff80", o_wb_data); end
    run_op(1'b0, 3'b100, 32'h10, 32'd7, 32'd0, 5'd3, 0, 0, 0, 0);
    n_cmp++; if (o_wb_data !== 32'h00000080) begin n_bad++; $display("FAIL lbu_data: got %h want 00000080", o_wb_data); end
    mem[0] = 32'h01234567; ref_mem[0] = 32'h01234567;
    run_op(1'b0, 3'b010, 32'h4, 32'hFFFFFFFC, 32'd0, 5'd0, 0, 0, 0, 0);
    n_cmp++; if (o_addr !== 5'd0 || o_wb_data !== 32'h01234567) begin n_bad++; $display("FAIL neg_imm: addr %0d data %h want 0/01234567", o_addr, o_wb_data); end
    n_cmp++; if (o_wb_cnt !== 1 || o_wb_rd !== 5'd0) begin n_bad++; $display("FAIL rd0_wb: count %0d rd %0d want 1/0", o_wb_cnt, o_wb_rd); end
  endtask

  task automatic test_sh();
    logic [3:0] c4, b4; logic [31:0] e, mw, l; logic [4:0] wi;
    model(1'b1, 3'b001, 32'h10, 32'd2, 32'h0000ABCD, c4, e, wi, b4, mw, l);
    run_op(1'b1, 3'b001, 32'h10, 32'd2, 32'h0000ABCD, 5'd0, 0, 0, 0, 0);
    n_cmp++; if (o_addr !== 5'd4 || o_we !== 1'b1) begin n_bad++; $display("FAIL sh_addr_we: addr %0d we %b want 4/1", o_addr, o_we); end
    n_cmp++; if (o_be !== 4'b1100) begin n_bad++; $display("FAIL sh_be: got %b want 1100", o_be); end
    n_cmp++; if (o_wdata !== 32'hABCDABCD) begin n_bad++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
    n_cmp++; if (o_done_c !== 2 || o_wb_cnt !== 0) begin n_bad++; $display("FAIL sh_done: cycle %0d wb %0d want 2/0", o_done_c, o_wb_cnt); end
  endtask

  task automatic test_exceptions();
    run_op(1'b0, 3'b010, 32'h0E, 32'd0, 32'd0, 5'd1, 0, 0, 0, 0);
    n_cmp++; if (o_exc_cnt !== 1 || o_cause !== 4'd4 || o_exc_addr !== 32'h0E) begin n_bad++; $display("FAIL exc_lw_mis: cnt %0d cause %0d addr %h want 1/4/0e", o_exc_cnt, o_cause, o_exc_addr); end
    n_cmp++; if (o_req_cnt !== 0 || o_done_c !== 1 || o_wb_cnt !== 0) begin n_bad++; $display("FAIL exc_lw_side: req %0d done@%0d wb %0d want 0/1/0", o_req_cnt, o_done_c, o_wb_cnt); end
    run_op(1'b0, 3'b011, 32'h20, 32'd0, 32'd0, 5'd1, 0, 0, 0, 0);
    n_cmp++; if (o_cause !== 4'd2 || o_req_cnt !== 0) begin n_bad++; $display("FAIL exc_illegal: cause %0d req %0d want 2/0", o_cause, o_req_cnt); end
    run_op(1'b1, 3'b010, 32'h0, 32'd1, 32'h55, 5'd0, 0, 0, 0, 0);
    n_cmp++; if (o_cause !== 4'd6 || o_exc_addr !== 32'h1 || o_req_cnt !== 0) begin n_bad++; $display("FAIL exc_sw_mis: cause %0d addr %h req %0d want 6/1/0", o_cause, o_exc_addr, o_req_cnt); end
  endtask

  task automatic test_back_to_back();
    mem[8] = 32'h0BADF00D; ref_mem[8] = 32'h0BADF00D;
    run_op(1'b0, 3'b010, 32'h20, 32'd0, 32'd0, 5'd7, 3, 2, 0, 1);
    n_cmp++; if (o_stable !== 1'b1 || o_req_cnt !== 4) begin n_bad++; $display("FAIL bp_stable: stable %b req cycles %0d want 1/4", o_stable, o_req_cnt); end
    n_cmp++; if (o_ready_low !== 1'b1) begin n_bad++; $display("FAIL bp_ready_low: ready rose while busy"); end
    n_cmp++; if (o_done_c !== 8 || o_wb_data !== 32'h0BADF00D) begin n_bad++; $display("FAIL bp_done: done@%0d data %h want 8/0badf00d", o_done_c, o_wb_data); end
    n_cmp++; if (o_ready_after !== 1'b1) begin n_bad++; $display("FAIL bp_idle: ready %b want 1", o_ready_after); end
    run_op(1'b0, 3'b010, 32'h20, 32'd0, 32'd0, 5'd7, 0, 0, 1, 0);
    n_cmp++; if (o_done_c !== 3 || o_wb_data !== 32'h0BADF00D || o_ready_low !== 1'b1) begin n_bad++; $display("FAIL bp_held_req: done@%0d data %h readylow %b want 3/0badf00d/1", o_done_c, o_wb_data, o_ready_low); end
  endtask

  task automatic test_reset_wait();
    int w = 0;
    mem[2] = 32'hCAFEF00D; ref_mem[2] = 32'hCAFEF00D;
    while (req_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    req_store = 1'b0; req_funct3 = 3'b010; req_base = 32'd0; req_imm = 32'd8; req_rd = 5'd4; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 5'd2) begin n_bad++; $display("FAIL rw_req: mem_req %b addr %0d want 1/2", mem_req, mem_addr); end
    mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL rw_async: ready %b mem_req %b want 1/0", req_ready, mem_req); end
    n_cmp++; if ({wb_valid, done, exc_valid, mem_we, mem_be, mem_addr, wb_data} !== '0) begin n_bad++; $display("FAIL rw_outputs: nonzero output during reset"); end
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk); mem_rvalid = 1'b0;
    n_cmp++; if (wb_valid !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rw_stray: wb %b done %b ready %b want 0/0/1", wb_valid, done, req_ready); end
    run_op(1'b0, 3'b010, 32'd0, 32'd8, 32'd0, 5'd4, 0, 0, 0, 0);
    n_cmp++; if (o_wb_data !== 32'hCAFEF00D || o_done_c !== 3) begin n_bad++; $display("FAIL rw_next: data %h done@%0d want cafef00d/3", o_wb_data, o_done_c); end
  endtask

  task automatic test_random();
    logic st; logic [2:0] f3; logic [31:0] base, imm, wd, ea, mwd, ld; logic [4:0] rd, wi;
    logic [3:0] cause, be;
    int gd, rvd, exp_done;
    for (int it = 0; it < 60; it++) begin
      st = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if ($urandom % 4 != 0) f3 = st ? 3'($urandom % 3) : ((($urandom % 5) < 3) ? 3'($urandom % 3) : 3'(4 + $urandom % 2));
      base = ($urandom % 4 == 0) ? $urandom : 32'($urandom_range(0, 255));
      imm  = 32'($urandom_range(0, 127)) - 32'd64;
      wd = $urandom; rd = 5'($urandom);
      gd = $urandom_range(0, 3); rvd = $urandom_range(0, 3);
      model(st, f3, base, imm, wd, cause, ea, wi, be, mwd, ld);
      run_op(st, f3, base, imm, wd, rd, gd, rvd, 0, 0);
      exp_done = (cause != 0) ? 1 : (st ? 2 + gd : 3 + gd + rvd);
      n_cmp++; if (o_done_c !== exp_done || o_done_cnt !== 1) begin n_bad++; $display("FAIL rnd%0d_done: done@%0d cnt %0d want %0d/1", it, o_done_c, o_done_cnt, exp_done); end
      n_cmp++; if (o_exc_cnt !== ((cause != 0) ? 1 : 0) || o_cause !== cause) begin n_bad++; $display("FAIL rnd%0d_exc: cnt %0d cause %0d want cause %0d", it, o_exc_cnt, o_cause, cause); end
      if (cause != 0) begin
        n_cmp++; if (o_exc_addr !== ea || o_req_cnt !== 0) begin n_bad++; $display("FAIL rnd%0d_excaddr: %h req %0d want %h/0", it, o_exc_addr, o_req_cnt, ea); end
      end else begin
        n_cmp++; if (o_addr !== wi || o_we !== st || o_be !== be || o_stable !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_mem: addr %0d we %b be %b stable %b want %0d/%b/%b/1", it, o_addr, o_we, o_be, o_stable, wi, st, be); end
        if (st) begin
          n_cmp++; if (o_wdata !== mwd || o_wb_cnt !== 0) begin n_bad++; $display("FAIL rnd%0d_st: wdata %h wb %0d want %h/0", it, o_wdata, o_wb_cnt, mwd); end
        end else begin
          n_cmp++; if (o_wb_data !== ld || o_wb_rd !== rd || o_wb_cnt !== 1) begin n_bad++; $display("FAIL rnd%0d_ld: data %h rd %0d want %h/%0d", it, o_wb_data, o_wb_rd, ld, rd); end
        end
      end
      n_cmp++; if (o_ready_after !== 1'b1 || o_ready_low !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ready: after %b low %b want 1/1", it, o_ready_after, o_ready_low); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_base = '0; req_imm = '0;
    req_wdata = '0; req_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 32; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_exceptions();
    test_back_to_back();
    test_reset_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the RV32 core, sitting directly downstream of decode/register read. It accepts one decoded LOAD or STORE per handshake, computes the effective address, and checks alignment and funct3 legality. Legal accesses are issued to a word-addressed data memory over a request/grant/response interface, with byte-lane steering for stores. Load data is sign- or zero-extended and returned as a register-file writeback.

## Interface
Parameters:
- `MEM_AW`, 5, data-memory word-address width (32 words).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_store` in 1: 1 = STORE, 0 = LOAD.
- `req_funct3` in 3: instruction funct3.
- `req_base` in 32: rs1 value.
- `req_imm` in 32: sign-extended I/S immediate.
- `req_wdata` in 32: rs2 value (stores).
- `req_rd` in 5: destination register (loads).
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write enable.
- `mem_addr` out MEM_AW: word address.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_be` out 4: byte enables.
- `mem_gnt` in 1: request accepted by memory.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read word.
- `wb_valid` out 1: load result pulse.
- `wb_rd` out 5: writeback register.
- `wb_data` out 32: extended load data.
- `done` out 1: retire pulse for every request (load, store, exception).
- `exc_valid` out 1: exception pulse.
- `exc_cause` out 4: 2 = illegal funct3, 4 = load misaligned, 6 = store misaligned.
- `exc_addr` out 32: faulting effective address.

## Operation
- States: IDLE, ADDR, REQ, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch all req fields, go to ADDR.
- ADDR:
  - Register `ea = req_base + req_imm` (mod 2^32).
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Other funct3 → cause 2.
  - Halfword with ea[0]≠0, or word with ea[1:0]≠0 → cause 4 (load) or 6 (store).
  - Exception → RESP with no memory access. Otherwise → REQ.
- REQ:
  - `mem_req`=1; `mem_addr = ea[MEM_AW+1:2]` (upper bits ignored, wraps).
  - Stores: `mem_we`=1. Byte: wdata={4{b}}, be=0001<<ea[1:0]. Half: wdata={2{h}}, be=0011<<ea[1:0]. Word: be=1111.
  - Loads: `mem_we`=0, be=1111.
  - All mem outputs are held stable until `mem_gnt`.
  - On gnt: store → RESP; load → WAIT.
- WAIT:
  - On `mem_rvalid`: extract byte `rdata>>(8*ea[1:0])` or half `rdata>>(16*ea[1])`.
  - Sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word through.
  - Register the result into `wb_data`, → RESP.
- RESP:
  - One cycle: `done`=1; `wb_valid`=1 for loads; `exc_valid`/`exc_cause`/`exc_addr` for exceptions.
  - → IDLE.
- rd=0 loads still pulse `wb_valid` with `wb_rd`=0; the register file discards them.
- `mem_rvalid` outside WAIT and `mem_gnt` outside REQ are ignored.

## Timing
- All outputs are registered.
- Reset value of every output is 0, except `req_ready`=1 after reset.
- Accept edge = E0. ADDR occupies E0→E1.
- `mem_req` is first high after E1.
- With zero-wait memory (gnt at E2, rvalid at E3):
  - Load `wb_valid` is high E3→E4.
  - Store `done` is high E2→E3.
  - Exception `done`/`exc_valid` is high E1→E2.
- Throughput: one request per RESP→IDLE cycle; `req_ready` is low from E0 until the return to IDLE.
- Async reset in any state: immediately → IDLE, all outputs 0, `mem_req` dropped.
  - An outstanding response is discarded; memory must tolerate an abandoned request.

## Structure
- Shared package `rv_pkg`:
  - LOAD/STORE opcodes and funct3 constants.
  - Exception cause codes.
  - LSU state enum.
- One combinational sub-module, `lsu_align`: store lane replication plus byte enables, and load extraction plus extension. It is shared by the REQ and WAIT logic.

## Test plan
- LW: base 0x10, imm 4, word5=0xDEADBEEF, gnt immediate, rvalid next cycle → `mem_addr`=5, `mem_we`=0, `wb_data`=0xDEADBEEF, `wb_valid` high E3→E4.
- LB and LBU at ea 0x17, word5=0x80FF1234 → LB returns 0xFFFFFF80, LBU returns 0x00000080. Negative imm case: base 0x4, imm −4 → `mem_addr`=0.
- SH at ea 0x12, wdata 0x0000ABCD → `mem_addr`=4, be=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1, `done` pulse, no `wb_valid`.
- Exceptions: LW at ea 0x0E → `exc_valid`, cause 4, `exc_addr`=0x0E, `mem_req` never asserted. funct3 011 → cause 2. SW at 0x01 → cause 6.
- Back-pressure: gnt delayed 3 cycles, then rvalid delayed 2 → `mem_*` stable throughout, `req_ready`=0, a held `req_valid` is accepted only after the return to IDLE.
- `rst_n` low during WAIT → all outputs 0 immediately. A stray `mem_rvalid` after release is ignored. The next LW completes correctly.
